rng_lfsr_gen: RTL and testbench

//  Parametrised pseudo-random number generator: one Galois LFSR of configurable length/taps, serialised

---
 rtl/rng_pkg.sv | 19 +
 rtl/lfsr_galois.sv | 32 +++
 rtl/rng_lfsr_gen.sv | 133 +++++++++++++
 tb/tb_rng_lfsr_gen.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rng_pkg.sv
// Shared definitions for the LFSR random word generator: FSM encoding,
// reference feedback masks for a few LFSR lengths, and the reject counter width.
package rng_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_CHECK = 2'd2,
      ST_DONE  = 2'd3
   } rng_state_e;

   // Maximal-length Galois masks, right-shift form.
   localparam logic [3:0]  TAPS_4  = 4'hC;
   localparam logic [10:0] TAPS_11 = 11'h500;
   localparam logic [16:0] TAPS_17 = 17'h12000;

   localparam int REJ_W = 8;

endpackage

// File: rtl/lfsr_galois.sv
// Right-shifting Galois LFSR with synchronous load and all-zero lockup recovery.
// bit_out is the LSB before the step, i.e. the bit produced by the next step.
module lfsr_galois #(
   parameter int           W    = 17,
   parameter logic [W-1:0] TAPS = 17'h12000,
   parameter logic [W-1:0] SEED = 17'h0B4D5
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         step,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic [W-1:0] state,
   output logic         bit_out
);

   assign bit_out = state[0];

   // A zero seed would lock the register, so it is replaced by SEED.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= SEED;
      end else if (load) begin
         state <= (load_val == '0) ? SEED : load_val;
      end else if (state == '0) begin
         state <= SEED;
      end else if (step) begin
         state <= (state >> 1) ^ (state[0] ? TAPS : '0);
      end
   end

endmodule

// File: rtl/rng_lfsr_gen.sv
// Handshaked random word source: serialises OUT_W LFSR bits per request and
// optionally rejects words >= LIMIT, regenerating until one is in range.
module rng_lfsr_gen
   import rng_pkg::*;
#(
   parameter int                LFSR_W   = 17,
   parameter logic [LFSR_W-1:0] TAPS     = 17'h12000,
   parameter logic [LFSR_W-1:0] SEED     = 17'h0B4D5,
   parameter int                OUT_W    = 3,
   parameter int                LIMIT    = 0,
   parameter bit                FREE_RUN = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              seed_load,
   input  logic [LFSR_W-1:0] seed_in,
   input  logic              req,
   output logic              req_rdy,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [OUT_W-1:0]  random,
   output logic [REJ_W-1:0]  rejects,
   output logic [1:0]        dbg_state,
   output logic [LFSR_W-1:0] dbg_lfsr
);

   // Handshakes: a request transfers on a rising edge where req & req_rdy;
   // a word transfers on a rising edge where out_valid & out_ready, and
   // out_valid/random stay stable until that edge.

   localparam int               CNT_W    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OUT_W - 1);
   localparam bit               LIMIT_EN = (LIMIT != 0);
   localparam logic [OUT_W:0]   LIMIT_X  = (OUT_W + 1)'(LIMIT);

   rng_state_e        state, state_nxt;
   logic [CNT_W-1:0]  bit_cnt;
   logic [OUT_W-1:0]  acc;
   logic [LFSR_W-1:0] lfsr;
   logic              lfsr_bit;
   logic              step;
   logic              reject;

   lfsr_galois #(
      .W    (LFSR_W),
      .TAPS (TAPS),
      .SEED (SEED)
   ) u_lfsr (
      .clk      (clk),
      .rst      (rst),
      .step     (step),
      .load     (seed_load),
      .load_val (seed_in),
      .state    (lfsr),
      .bit_out  (lfsr_bit)
   );

   assign reject    = LIMIT_EN && ({1'b0, acc} >= LIMIT_X);
   assign out_valid = (state == ST_DONE);
   assign dbg_state = state;
   assign dbg_lfsr  = lfsr;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      step      = 1'b0;
      req_rdy   = 1'b0;
      case (state)
         ST_IDLE: begin
            req_rdy = ~seed_load;
            step    = FREE_RUN;
            if (req && !seed_load) state_nxt = ST_SHIFT;
         end
         ST_SHIFT: begin
            step = 1'b1;
            if (bit_cnt == CNT_LAST) state_nxt = ST_CHECK;
         end
         ST_CHECK: begin
            state_nxt = reject ? ST_SHIFT : ST_DONE;
         end
         ST_DONE: begin
            step = FREE_RUN;
            if (out_ready) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
      // Reseeding abandons whatever word is in flight.
      if (seed_load) state_nxt = ST_IDLE;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bit_cnt <= '0;
         acc     <= '0;
         random  <= '0;
         rejects <= '0;
      end else if (seed_load) begin
         bit_cnt <= '0;
         acc     <= '0;
         rejects <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req) begin
                  bit_cnt <= '0;
                  acc     <= '0;
               end
            end
            ST_SHIFT: begin
               acc     <= OUT_W'({acc, lfsr_bit});
               bit_cnt <= bit_cnt + CNT_W'(1);
            end
            ST_CHECK: begin
               bit_cnt <= '0;
               if (reject) begin
                  if (rejects != '1) rejects <= rejects + REJ_W'(1);
               end else begin
                  random <= acc;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_rng_lfsr_gen.sv
// Bench for rng_lfsr_gen: two instances (unlimited and LIMIT=6) checked every
// cycle against a transaction-level model, plus hand-computed directed values.
module tb_rng_lfsr_gen;
   import rng_pkg::*;

   localparam logic [3:0] TAPS_V = 4'hC;
   localparam logic [3:0] SEED_V = 4'b1010;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic       seed_load [2];
   logic [3:0] seed_in   [2];
   logic       req       [2];
   logic       req_rdy   [2];
   logic       out_valid [2];
   logic       out_ready [2];
   logic [2:0] random    [2];
   logic [7:0] rejects   [2];
   logic [1:0] dbg_state [2];
   logic [3:0] dbg_lfsr  [2];

   rng_lfsr_gen #(.LFSR_W(4), .TAPS(TAPS_V), .SEED(SEED_V), .OUT_W(3), .LIMIT(0), .FREE_RUN(1'b0)) u_dut (
      .clk(clk), .rst(rst), .seed_load(seed_load[0]), .seed_in(seed_in[0]), .req(req[0]),
      .req_rdy(req_rdy[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]), .random(random[0]),
      .rejects(rejects[0]), .dbg_state(dbg_state[0]), .dbg_lfsr(dbg_lfsr[0]));

   rng_lfsr_gen #(.LFSR_W(4), .TAPS(TAPS_V), .SEED(SEED_V), .OUT_W(3), .LIMIT(6), .FREE_RUN(1'b0)) u_lim (
      .clk(clk), .rst(rst), .seed_load(seed_load[1]), .seed_in(seed_in[1]), .req(req[1]),
      .req_rdy(req_rdy[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]), .random(random[1]),
      .rejects(rejects[1]), .dbg_state(dbg_state[1]), .dbg_lfsr(dbg_lfsr[1]));

   // ---------------- scoreboard counters ----------------
   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- transaction-level model ----------------
   // On accept the whole delivered word, rejection count and final LFSR value
   // are computed up front; latency is (OUT_W+1) cycles per generated word.
   logic [3:0] m_lfsr   [2];
   logic [2:0] m_word   [2];
   logic [2:0] m_random [2];
   bit         m_busy   [2];
   int         m_cyc    [2];
   int         m_lat    [2];
   int         m_rejects[2];
   int         m_limit  [2] = '{0, 6};

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_lfsr[i] = SEED_V; m_word[i] = '0; m_random[i] = '0;
         m_busy[i] = 1'b0; m_cyc[i] = 0; m_lat[i] = 0; m_rejects[i] = 0;
      end
   endtask

   task automatic model_accept(input int i);
      logic [3:0] l;
      logic [2:0] w;
      int nrej;
      l = m_lfsr[i];
      w = '0;
      nrej = 0;
      for (int t = 0; t < 64; t++) begin
         w = '0;
         for (int b = 0; b < 3; b++) begin
            w = {w[1:0], l[0]};
            l = (l >> 1) ^ (l[0] ? TAPS_V : 4'h0);
         end
         if (m_limit[i] != 0 && int'(w) >= m_limit[i]) nrej++;
         else break;
      end
      m_word[i] = w;
      m_lfsr[i] = l;
      m_lat[i]  = 4 * (nrej + 1);
      m_cyc[i]  = 0;
      m_busy[i] = 1'b1;
   endtask

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         model_reset();
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (seed_load[i]) begin
               m_lfsr[i] = (seed_in[i] == 4'h0) ? SEED_V : seed_in[i];
               m_busy[i] = 1'b0;
               m_rejects[i] = 0;
            end else if (!m_busy[i]) begin
               if (req[i]) model_accept(i);
            end else if (m_cyc[i] >= m_lat[i]) begin
               if (out_ready[i]) m_busy[i] = 1'b0;
            end else begin
               m_cyc[i]++;
               if (m_cyc[i] == m_lat[i]) m_random[i] = m_word[i];
               else if (m_cyc[i] % 4 == 0 && m_rejects[i] < 255) m_rejects[i]++;
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         bit exp_valid;
         exp_valid = m_busy[i] && (m_cyc[i] >= m_lat[i]);
         chk($sformatf("cyc_out_valid[%0d]", i), int'(out_valid[i]), int'(exp_valid));
         chk($sformatf("cyc_random[%0d]", i), int'(random[i]), int'(m_random[i]));
         chk($sformatf("cyc_rejects[%0d]", i), int'(rejects[i]), m_rejects[i]);
         chk($sformatf("cyc_req_rdy[%0d]", i), int'(req_rdy[i]), int'(!m_busy[i] && !seed_load[i]));
         if (!m_busy[i]) begin
            chk($sformatf("cyc_idle_lfsr[%0d]", i), int'(dbg_lfsr[i]), int'(m_lfsr[i]));
            chk($sformatf("cyc_idle_state[%0d]", i), int'(dbg_state[i]), int'(ST_IDLE));
         end else if (exp_valid) begin
            chk($sformatf("cyc_done_lfsr[%0d]", i), int'(dbg_lfsr[i]), int'(m_lfsr[i]));
            chk($sformatf("cyc_done_state[%0d]", i), int'(dbg_state[i]), int'(ST_DONE));
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic do_req(input int i);
      @(posedge clk); #1 req[i] = 1'b1;
      @(posedge clk); #1 req[i] = 1'b0;
   endtask

   task automatic wait_valid(input int i, output int n);
      n = 0;
      while (!out_valid[i] && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   task automatic load_seed(input int i, input logic [3:0] s);
      @(posedge clk); #1 seed_load[i] = 1'b1; seed_in[i] = s;
      @(posedge clk); #1 seed_load[i] = 1'b0;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int n;
      rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         seed_load[i] = 1'b0; seed_in[i] = '0; req[i] = 1'b0; out_ready[i] = 1'b1;
      end
      #12;
      chk("reset_out_valid", int'(out_valid[0]), 0);
      chk("reset_random", int'(random[0]), 0);
      chk("reset_rejects", int'(rejects[0]), 0);
      chk("reset_lfsr", int'(dbg_lfsr[0]), int'(SEED_V));
      #11 rst = 1'b1;

      // 1: first word from SEED
      do_req(0); wait_valid(0, n);
      chk("t1_latency", n, 4);
      chk("t1_random", int'(random[0]), 3'b010);
      chk("t1_lfsr", int'(dbg_lfsr[0]), 4'b0111);
      chk("t1_rejects", int'(rejects[0]), 0);
      @(posedge clk); #1;

      // 2: second word, no limit
      do_req(0); wait_valid(0, n);
      chk("t2_latency", n, 4);
      chk("t2_random", int'(random[0]), 3'b111);
      chk("t2_lfsr", int'(dbg_lfsr[0]), 4'b1001);
      @(posedge clk); #1;

      // 3: LIMIT=6, second word 3'b111 is rejected
      do_req(1); wait_valid(1, n);
      chk("t3_first_random", int'(random[1]), 3'b010);
      @(posedge clk); #1;
      do_req(1); wait_valid(1, n);
      chk("t3_reject_latency", n, 8);
      chk("t3_random", int'(random[1]), 3'b100);
      chk("t3_rejects", int'(rejects[1]), 1);
      @(posedge clk); #1;

      // 4: consumer stalls in DONE
      out_ready[0] = 1'b0;
      do_req(0); wait_valid(0, n);
      chk("t4_latency", n, 4);
      repeat (10) begin
         @(posedge clk); #1;
         chk("t4_hold_valid", int'(out_valid[0]), 1);
         chk("t4_hold_random", int'(random[0]), 3'b100);
         chk("t4_hold_req_rdy", int'(req_rdy[0]), 0);
         chk("t4_hold_lfsr", int'(dbg_lfsr[0]), 4'b0010);
      end
      out_ready[0] = 1'b1;
      @(posedge clk); #1;
      chk("t4_released", int'(out_valid[0]), 0);

      // 5: zero seed loaded mid-SHIFT falls back to SEED
      do_req(0);
      @(posedge clk); #1 seed_load[0] = 1'b1; seed_in[0] = 4'h0;
      @(posedge clk); #1 seed_load[0] = 1'b0;
      chk("t5_state", int'(dbg_state[0]), int'(ST_IDLE));
      chk("t5_out_valid", int'(out_valid[0]), 0);
      chk("t5_lfsr", int'(dbg_lfsr[0]), int'(SEED_V));
      chk("t5_rejects", int'(rejects[0]), 0);
      chk("t5_random_kept", int'(random[0]), 3'b100);
      do_req(0); wait_valid(0, n);
      chk("t5_after_random", int'(random[0]), 3'b010);
      @(posedge clk); #1;

      // Non-zero reseed on the limited instance clears rejects
      load_seed(1, 4'b0111);
      chk("seed_lfsr", int'(dbg_lfsr[1]), 4'b0111);
      chk("seed_rejects", int'(rejects[1]), 0);
      do_req(1); wait_valid(1, n);
      chk("seed_latency", n, 8);
      chk("seed_random", int'(random[1]), 3'b100);
      chk("seed_rejects_after", int'(rejects[1]), 1);
      @(posedge clk); #1;

      // Back-to-back requests with req held high
      req[1] = 1'b1;
      repeat (40) @(posedge clk);
      #1 req[1] = 1'b0;
      repeat (40) @(posedge clk);
      #1;

      // 6: asynchronous reset while in CHECK
      do_req(0);
      repeat (3) @(posedge clk);
      #3 rst = 1'b0;
      #1;
      chk("t6_out_valid", int'(out_valid[0]), 0);
      chk("t6_random", int'(random[0]), 0);
      chk("t6_rejects", int'(rejects[1]), 0);
      chk("t6_lfsr", int'(dbg_lfsr[0]), int'(SEED_V));
      chk("t6_state", int'(dbg_state[0]), int'(ST_IDLE));
      #2 rst = 1'b1;
      do_req(0); wait_valid(0, n);
      chk("t6_after_random", int'(random[0]), 3'b010);
      repeat (3) @(posedge clk);
      #1;

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
